// File: rtl/sram_fifo_pkg.sv
// Shared constants for the SRAM ring-buffer controller: SRAM port encodings and default widths.
package sram_fifo_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned DROP_W     = 16;

  localparam logic CMD_WRITE = 1'b0;
  localparam logic CMD_READ  = 1'b1;
  localparam logic CEB_ON    = 1'b0;
  localparam logic CEB_OFF   = 1'b1;

endpackage

// File: rtl/sram_fifo_rdpipe.sv
// Read side of the ring buffer: issue decision, one-cycle read-in-flight flag and the output register.
module sram_fifo_rdpipe
  import sram_fifo_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              empty,
  input  logic              out_ready,
  input  logic [DATA_W-1:0] q2,
  output logic              rd_go_c,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic              rd_pend_q, rd_pend_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  // Issue only when SRAM holds a word, nothing is in flight and the output register frees up this edge.
  assign rd_go_c = rst_n && !empty && !rd_pend_q && !clr && (!out_valid_q || out_ready);

  // Next state: capture the SRAM word one cycle after issue, otherwise pop on handshake.
  always_comb begin
    rd_pend_d   = rd_go_c;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (clr) begin
      out_valid_d = 1'b0;
    end else if (rd_pend_q) begin
      out_valid_d = 1'b1;
      out_data_d  = q2;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Read-pipe state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      rd_pend_q   <= rd_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Stream-to-SRAM ring-buffer controller in front of a dual-port SRAM (port 1 write, port 2 read).
// Build option SRAM_FIFO_DROP_CNT_EN adds a saturating 16-bit dropped-sample counter on DROP_CNT.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              CLR,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              CEB1,
  output logic              CMD1,
  output logic [ADDR_W-1:0] ADD1,
  output logic [DATA_W-1:0] DIN1,
  output logic              CEB2,
  output logic              CMD2,
  output logic [ADDR_W-1:0] ADD2,
  input  logic [DATA_W-1:0] Q2,
  output logic [ADDR_W:0]   LEVEL,
  output logic              EMPTY,
  output logic              FULL,
  output logic              OVF,
  output logic [DROP_W-1:0] DROP_CNT
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LVL_W = ADDR_W + 1;

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              ovf_q, ovf_d;
  logic              full_c, empty_c, wr_go_c, rd_go_c, drop_c;

  assign full_c  = (level_q == LVL_W'(DEPTH));
  assign empty_c = (level_q == '0);
  // RSTN gating keeps the write enable off while reset is asserted, even with IN_VALID high.
  assign wr_go_c = RSTN && IN_VALID && !full_c && !CLR;
  assign drop_c  = IN_VALID && full_c && !CLR;

  sram_fifo_rdpipe #(
    .DATA_W (DATA_W)
  ) u_rdpipe (
    .clk       (CLK),
    .rst_n     (RSTN),
    .clr       (CLR),
    .empty     (empty_c),
    .out_ready (OUT_READY),
    .q2        (Q2),
    .rd_go_c   (rd_go_c),
    .out_valid (OUT_VALID),
    .out_data  (OUT_DATA)
  );

  // Pointer, fill level and overflow flag next state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (CLR) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (wr_go_c) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (rd_go_c) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      if (wr_go_c && !rd_go_c) level_d = level_q + LVL_W'(1);
      else if (!wr_go_c && rd_go_c) level_d = level_q - LVL_W'(1);
      if (drop_c) ovf_d = 1'b1;
    end
  end

  // Ring-buffer state registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef SRAM_FIFO_DROP_CNT_EN
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of samples lost while full.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (CLR) drop_cnt_d = '0;
    else if (drop_c && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + DROP_W'(1);
  end

  // Drop counter register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign DROP_CNT = drop_cnt_q;
`else
  assign DROP_CNT = '0;
`endif

  assign CEB1  = wr_go_c ? CEB_ON : CEB_OFF;
  assign CMD1  = CMD_WRITE;
  assign ADD1  = wr_ptr_q;
  assign DIN1  = IN_DATA;
  assign CEB2  = rd_go_c ? CEB_ON : CEB_OFF;
  assign CMD2  = CMD_READ;
  assign ADD2  = rd_ptr_q;
  assign LEVEL = level_q;
  assign EMPTY = empty_c;
  assign FULL  = full_c;
  assign OVF   = ovf_q;

endmodule
